vga_scanout: RTL and testbench
==============================

Name: vga_scanout

Overview:
- Read-side (VGA) master of the dual-port VRAM.
- The CPU writes 48-bit words into the VRAM. This block generates VGA 640x480@60 timing, issues VRAM read addresses on the VGA port, and unpacks each 6-byte word into six 8-bit grayscale pixels.
- The image is IMG_W x IMG_H pixels, drawn at the top-left of the active area; everything else in the active area is black.
- Sits between the VRAM VGA port and the board DAC/pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel; must be >=2
- IMG_W, 384, image width in pixels; multiple of 6
- IMG_H, 256, image height in lines

Ports:
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- a_vga  output  17  VRAM word address, VGA port
- vram_i  input  [5:0][7:0]  VRAM read data; 1 clk latency after a_vga; byte [0] is the leftmost pixel
- vga_r  output  8  red
- vga_g  output  8  green
- vga_b  output  8  blue
- vga_hs  output  1  hsync, active low
- vga_vs  output  1  vsync, active low
- vga_blank_n  output  1  high during the active area
- vga_clk  output  1  pixel clock, 50% duty for even CLK_DIV
- frame_start  output  1  one-clk pulse on the pixel tick at (h=0, v=0)

Behaviour:
- Reset: every output goes low except vga_hs=1 and vga_vs=1. Also cleared: a_vga=0, counters, shift register, div counter.
- Reset asserted mid-frame aborts the frame. The first tick after release is (0,0) and raises frame_start.
- Pixel tick:
  - div_cnt counts 0..CLK_DIV-1; tick = (div_cnt==CLK_DIV-1).
  - vga_clk = (div_cnt >= CLK_DIV/2).
- Counters (advance on tick only):
  - h counts 0..H_TOTAL-1 (800). On wrap, v increments over 0..V_TOTAL-1 (525), then wraps to 0.
- Sync, combinational on (h,v):
  - hs_n = !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]); vs_n likewise on v.
  - active = h<H_ACTIVE && v<V_ACTIVE.
  - in_img = h<IMG_W && v<IMG_H.
- Output register: updated on each tick from the current (h,v). Fixed one-tick latency from counter to pins, equal for sync and pixel data.
- Pixel data:
  - RGB = {b,b,b} where b is the current byte when in_img, else 0.
  - RGB is 0 whenever !active.
- Fetch pipeline:
  - WPL = IMG_W/6 words per line. Words are row-major, address = v*WPL + h/6, built with running counters only (no multiplier).
  - Word k of a line is requested on the tick at h = 6k-1. For k=0 that is h = H_TOTAL-1 of the previous line, or of line V_TOTAL-1 when v=0.
  - vram_i is captured into next_word one clk later.
  - On the tick with h%6==0 and in_img, next_word loads into the 6-byte shift register. Otherwise the register shifts one byte per in_img tick.
  - The CLK_DIV>=2 constraint guarantees data is captured before it is used.
- Address rules:
  - a_vga holds its value between fetches.
  - Line base advances by WPL after each image line.
  - Base resets to 0 at the end of the frame; after the last word (IMG_H*WPL-1) the next fetch is address 0 of the next frame.
  - No fetches for v>=IMG_H or h>=IMG_W-1.
- Width: address arithmetic is 17-bit. IMG_H*WPL must be <=2^17, checked by an elaboration assertion.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode=1: eight vertical colour bars of 80 px inside the active area: white, yellow, cyan, green, magenta, red, blue, black, each component 8'hFF or 8'h00.
  - Address generation continues unchanged.
  - test_mode is sampled only at frame_start; no mid-frame switching.
- Undefined: no port, no pattern logic, VRAM output only.

Test Plan:
- Reset: assert rst 3 clks mid-line -> all outputs 0 except hs=vs=1; first tick after release gives frame_start=1 and a_vga=0.
- Horizontal timing: run one line -> vga_hs low exactly 96 ticks (192 clks) starting at output tick 657; line period 1600 clks; blank_n high for 640 ticks.
- Vertical timing: run full frame -> vga_vs low for 2 lines starting at line 490; frame_start period 840000 clks.
- Pixel unpack: VRAM model with word k byte i = (6k+i)%256 -> pixel (x,y) out = {p,p,p}, p=(y*384+x)%256, for x<384, y<256.
- Addressing and wrap: monitor a_vga -> line 0 requests 0..63, line 1 starts at 64, last request 16383 at line 255, next frame restarts at 0; pixels at x>=384 or y>=256 are 0.
- With VGA_TEST_PATTERN_EN and test_mode=1 set before frame_start -> pixel x=85 is {FF,FF,00}, x=639 is {00,00,00}.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout
// -----------------------------------------------------------------------------
// VGA read-side master of the dual-port VRAM. Generates 640x480@60 style
// timing from the system clock, fetches 48-bit words from the VRAM VGA port
// and unpacks every word into six 8-bit grayscale pixels. The image of
// IMG_W x IMG_H pixels sits at the top-left of the active area; every other
// active pixel is black.
//
// Optional feature: define VGA_TEST_PATTERN_EN to add the test_mode input,
// which replaces the active area with eight 80-pixel colour bars. test_mode
// is sampled once per frame, on the frame_start tick.
//
// Ports
//   clk          system clock, all logic on its rising edge
//   rst          synchronous, active-high reset
//   test_mode    (VGA_TEST_PATTERN_EN only) colour-bar select
//   a_vga        VRAM word address, held between fetches
//   vram_i       VRAM read data, sampled one clk after a_vga changes;
//                byte [0] is the leftmost pixel
//   vga_r/g/b    8-bit colour components
//   vga_hs       hsync, active low
//   vga_vs       vsync, active low
//   vga_blank_n  high during the active area
//   vga_clk      pixel clock (50% duty for even CLK_DIV)
//   frame_start  one-clk pulse on the pixel tick at (h=0, v=0)
//
// Handshake: there is no valid/ready pair. A fetch is issued by updating
// a_vga on a pixel tick; the word for that address is expected on vram_i in
// the very next clk and is unconditionally captured into next_word then.
// -----------------------------------------------------------------------------
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int IMG_W    = 384,
    parameter int IMG_H    = 256
) (
    input  logic            clk,
    input  logic            rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic            test_mode,
`endif
    output logic [16:0]     a_vga,
    input  logic [5:0][7:0] vram_i,
    output logic [7:0]      vga_r,
    output logic [7:0]      vga_g,
    output logic [7:0]      vga_b,
    output logic            vga_hs,
    output logic            vga_vs,
    output logic            vga_blank_n,
    output logic            vga_clk,
    output logic            frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int WPL      = IMG_W / 6;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("vga_scanout: CLK_DIV must be >= 2");
        end
        if ((IMG_W % 6) != 0) begin : g_bad_img_w
            $error("vga_scanout: IMG_W must be a multiple of 6");
        end
        if (IMG_H * WPL > 131072) begin : g_bad_img_size
            $error("vga_scanout: IMG_H*IMG_W/6 exceeds the 17-bit address space");
        end
    endgenerate

    logic [DW-1:0]   div_cnt;
    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic [2:0]      ph;          // h mod 6, restarted at every line wrap
    logic [16:0]     addr_cnt;    // next sequential word address
    logic            fetch_pend;  // a_vga was updated in the previous clk
    logic [5:0][7:0] next_word;
    logic [5:0][7:0] shreg;

    logic            tick;
    logic            h_last;
    logic            v_last;
    logic            hs_n;
    logic            vs_n;
    logic            active;
    logic            in_img;
    logic            next_line_in_img;
    logic            fetch;
    logic [7:0]      cur_byte;
    logic [23:0]     pix_rgb;

`ifdef VGA_TEST_PATTERN_EN
    logic            test_q;
    logic            mode_now;
    logic [2:0]      bar_idx;
    logic [23:0]     bar_rgb;
`endif

    always_comb begin
        tick     = (int'(div_cnt) == CLK_DIV - 1);
        h_last   = (int'(h) == H_TOTAL - 1);
        v_last   = (int'(v) == V_TOTAL - 1);
        hs_n     = !((int'(h) >= HS_FIRST) && (int'(h) <= HS_LAST));
        vs_n     = !((int'(v) >= VS_FIRST) && (int'(v) <= VS_LAST));
        active   = (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
        in_img   = (int'(h) < IMG_W) && (int'(v) < IMG_H);

        // Word 0 of a line is fetched on the last tick of the line before;
        // the last line of the frame prefetches line 0 of the next frame.
        next_line_in_img = v_last ? 1'b1 : (int'(v) + 1 < IMG_H);

        // Word k (k>=1) is fetched on h = 6k-1 inside the image line.
        fetch = tick && ((h_last && next_line_in_img) ||
                         ((ph == 3'd5) && in_img && (int'(h) < IMG_W - 1)));

        // The shift register holds the bytes after the current one, so on
        // a word boundary the leftmost byte comes straight from next_word.
        cur_byte = (ph == 3'd0) ? next_word[0] : shreg[0];
    end

`ifdef VGA_TEST_PATTERN_EN
    always_comb begin
        // test_mode takes effect on the frame_start tick itself.
        mode_now = frame_start ? test_mode : test_q;
        bar_idx  = 3'(int'(h) / 80);
        // Bars: white, yellow, cyan, green, magenta, red, blue, black.
        bar_rgb  = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
    end
`endif

    always_comb begin
        pix_rgb = 24'h000000;
        if (active && in_img) begin
            pix_rgb = {cur_byte, cur_byte, cur_byte};
        end
`ifdef VGA_TEST_PATTERN_EN
        if (active && mode_now) begin
            pix_rgb = bar_rgb;
        end
`endif
    end

    assign frame_start = tick && (h == '0) && (v == '0);
    assign vga_clk     = (int'(div_cnt) >= CLK_DIV / 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            h           <= '0;
            v           <= '0;
            ph          <= 3'd0;
            a_vga       <= 17'd0;
            // a_vga=0 is treated as already issued, so the frame that
            // follows reset gets word 0 captured and continues from 1.
            addr_cnt    <= 17'd1;
            fetch_pend  <= 1'b1;
            next_word   <= '0;
            shreg       <= '0;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            test_q      <= 1'b0;
`endif
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DW'(1);
            fetch_pend <= fetch;

            if (fetch_pend) begin
                next_word <= vram_i;
            end

            if (fetch) begin
                if (h_last && v_last) begin
                    a_vga    <= 17'd0;
                    addr_cnt <= 17'd1;
                end else begin
                    a_vga    <= addr_cnt;
                    addr_cnt <= addr_cnt + 17'd1;
                end
            end

            if (tick) begin
                if (h_last) begin
                    h  <= '0;
                    ph <= 3'd0;
                    v  <= v_last ? '0 : v + VW'(1);
                end else begin
                    h  <= h + HW'(1);
                    ph <= (ph == 3'd5) ? 3'd0 : ph + 3'd1;
                end

                if (in_img) begin
                    if (ph == 3'd0) begin
                        shreg <= {8'h00, next_word[5:1]};
                    end else begin
                        shreg <= {8'h00, shreg[5:1]};
                    end
                end

`ifdef VGA_TEST_PATTERN_EN
                if (frame_start) begin
                    test_q <= test_mode;
                end
`endif

                vga_hs      <= hs_n;
                vga_vs      <= vs_n;
                vga_blank_n <= active;
                vga_r       <= pix_rgb[23:16];
                vga_g       <= pix_rgb[15:8];
                vga_b       <= pix_rgb[7:0];
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
// -----------------------------------------------------------------------------
// Bench for vga_scanout with a reduced raster so that several frames fit in a
// short run. The VRAM is filled with random bytes and answers combinationally
// from a_vga, i.e. the word is on vram_i in the clk after a_vga changes.
// Expected outputs come from the raster arithmetic: tick n is pixel
// (n mod H_TOTAL, n div H_TOTAL mod V_TOTAL), pixel data is word
// y*WPL + x/6, byte x mod 6, and the registered outputs show the last tick.
// Build with VGA_TEST_PATTERN_EN defined to exercise the colour bars.
// -----------------------------------------------------------------------------
module tb_vga_scanout;

    localparam int CD   = 2;
    localparam int HA   = 176;
    localparam int HFP  = 8;
    localparam int HSY  = 16;
    localparam int HBP  = 8;
    localparam int VA   = 20;
    localparam int VFP  = 2;
    localparam int VSY  = 2;
    localparam int VBP  = 3;
    localparam int IW   = 96;
    localparam int IH   = 12;
    localparam int HT   = HA + HFP + HSY + HBP;
    localparam int VT   = VA + VFP + VSY + VBP;
    localparam int WPL  = IW / 6;
    localparam int FRAME_TICKS = HT * VT;
    localparam int FRAME_CLKS  = FRAME_TICKS * CD;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef VGA_TEST_PATTERN_EN
    logic test_mode;
`endif
    logic [16:0]     a_vga;
    logic [5:0][7:0] vram_i;
    logic [7:0]      vga_r;
    logic [7:0]      vga_g;
    logic [7:0]      vga_b;
    logic            vga_hs;
    logic            vga_vs;
    logic            vga_blank_n;
    logic            vga_clk;
    logic            frame_start;

    logic [5:0][7:0] mem [256];
    assign vram_i = (a_vga < 17'd256) ? mem[a_vga[7:0]] : '0;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CLK_DIV(CD), .IMG_W(IW), .IMG_H(IH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .a_vga       (a_vga),
        .vram_i      (vram_i),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_clk     (vga_clk),
        .frame_start (frame_start)
    );

    // scoreboard state
    int          tests = 0;
    int          fails = 0;
    int          j = 0;          // clk edges since reset release
    int          fs_seen = 0;
    logic [16:0] a_max = 17'd0;
    logic        exp_hs;
    logic        exp_vs;
    logic        exp_blank;
    logic        exp_mode;
    logic [23:0] exp_rgb;
    int          exp_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, expv, j);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int x);
        case (x / 80)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference for what tick n puts on the pins and on a_vga.
    task automatic model_tick(input int n);
        int x;
        int y;
        int ny;
        x  = n % HT;
        y  = (n / HT) % VT;
        ny = (y + 1) % VT;
`ifdef VGA_TEST_PATTERN_EN
        if (x == 0 && y == 0) exp_mode = test_mode;
`endif
        exp_hs    = !(x >= HA + HFP && x < HA + HFP + HSY);
        exp_vs    = !(y >= VA + VFP && y < VA + VFP + VSY);
        exp_blank = (x < HA) && (y < VA);
        exp_rgb   = 24'h000000;
        if (exp_blank && x < IW && y < IH)
            exp_rgb = {3{mem[y * WPL + x / 6][x % 6]}};
        if (exp_blank && exp_mode)
            exp_rgb = bar_colour(x);
        if (y < IH && x % 6 == 5 && x < IW - 1)
            exp_a = y * WPL + (x + 1) / 6;
        else if (x == HT - 1 && ny < IH)
            exp_a = ny * WPL;
    endtask

    task automatic check_sample();
        logic exp_fs;
        logic exp_clk;
        exp_fs  = ((j + 1) % CD == 0) && ((((j + 1) / CD) - 1) % FRAME_TICKS == 0);
        exp_clk = (j % CD) >= CD / 2;
        chk("hs", 32'(vga_hs), 32'(exp_hs));
        chk("vs", 32'(vga_vs), 32'(exp_vs));
        chk("blank_n", 32'(vga_blank_n), 32'(exp_blank));
        chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_rgb));
        chk("a_vga", 32'(a_vga), 32'(exp_a));
        chk("vga_clk", 32'(vga_clk), 32'(exp_clk));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
        if (frame_start) fs_seen++;
        if (a_vga > a_max) a_max = a_vga;
    endtask

    task automatic check_reset_state();
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        chk("rst_blank_n", 32'(vga_blank_n), 32'd0);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("rst_a_vga", 32'(a_vga), 32'd0);
        chk("rst_vga_clk", 32'(vga_clk), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
    endtask

    // driver tasks, called at the falling edge
    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_state();
        end
        rst       = 1'b0;
        j         = 0;
        fs_seen   = 0;
        exp_a     = 0;
        exp_hs    = 1'b1;
        exp_vs    = 1'b1;
        exp_blank = 1'b0;
        exp_rgb   = 24'h000000;
        exp_mode  = 1'b0;
    endtask

    task automatic run_clks(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            j++;
            if (j % CD == 0) model_tick(j / CD - 1);
            @(negedge clk);
            check_sample();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int b = 0; b < 6; b++)
                mem[i][b] = 8'($urandom_range(0, 255));
        rst = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif

        // power-on reset, then one full frame plus a few lines
        do_reset(3);
        run_clks(FRAME_CLKS + CD * (HT * 3 + $urandom_range(20, 150)));
        chk("a_vga_max", 32'(a_max), 32'(IH * WPL - 1));

        // reset in the middle of a line aborts the frame
        do_reset(3);
`ifdef VGA_TEST_PATTERN_EN
        run_clks(FRAME_CLKS / 2);
        test_mode = 1'b1;
        run_clks(FRAME_CLKS * 3 / 2 + 200);
`else
        run_clks(FRAME_CLKS * 2 + 200);
`endif
        chk("frame_start_count", 32'(fs_seen), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
